// File: rtl/pcie_msi_irq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pcie_msi_irq_ctrl
// Description : MSI interrupt generator. It latches per-source requests as
//               pending bits and arbitrates between them round-robin. It
//               issues one MSI at a time on the PCIe hard-block
//               cfg_interrupt_msi_* interface, folds vectors into the
//               host-granted count, and retries with a backoff after a fail.
// Options     : PCIE_MSI_IRQ_TIMEOUT_EN - adds a WAIT watchdog. An
//               unanswered message is treated as a fail after
//               TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_msi_irq_ctrl #(
    parameter int IRQ_COUNT      = 32,   // 1..32
    parameter int RETRY_DELAY    = 16,   // >= 1
    parameter int FAIL_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IRQ_COUNT-1:0]      irq_req,
    output logic [IRQ_COUNT-1:0]      irq_pending,
    output logic                      busy,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    input  logic [3:0]                cfg_interrupt_msi_enable,
    input  logic [11:0]               cfg_interrupt_msi_mmenable,
    output logic [31:0]               cfg_interrupt_msi_int,
    input  logic                      cfg_interrupt_msi_sent,
    input  logic                      cfg_interrupt_msi_fail,
    output logic [3:0]                cfg_interrupt_msi_function_number,
    output logic [2:0]                cfg_interrupt_msi_attr
);

    localparam int                 c_PTR_W    = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
    localparam int                 c_BO_W     = $clog2(RETRY_DELAY + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(IRQ_COUNT - 1);
    localparam logic [c_BO_W-1:0]  c_BO_LAST  = c_BO_W'(RETRY_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_BACKOFF = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IRQ_COUNT-1:0]      r_pending;
    logic [c_PTR_W-1:0]        r_ptr;
    logic [c_PTR_W-1:0]        r_k;
    logic [31:0]               r_msi_int;
    logic [FAIL_CNT_WIDTH-1:0] r_fail_count;
    logic [c_BO_W-1:0]         r_backoff_cnt;

    logic                      w_found;
    logic [c_PTR_W-1:0]        w_pick;
    logic                      w_grant;
    logic                      w_fail_evt;
    logic                      w_timeout;
    logic [IRQ_COUNT-1:0]      w_clear;
    logic [IRQ_COUNT-1:0]      w_requeue;
    logic [4:0]                w_vec_mask;
    logic [4:0]                w_vec_idx;
    logic [c_PTR_W-1:0]        w_ptr_nxt;

    // Only function 0 and the 3-bit multiple-message-enable field matter here.
    logic w_unused_cfg_bits;
    assign w_unused_cfg_bits = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    // Round-robin search: first pending bit at or after the pointer, wrapping.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= IRQ_COUNT) begin
                idx = idx - IRQ_COUNT;
            end
            if (!w_found && r_pending[idx]) begin
                w_found = 1'b1;
                w_pick  = idx[c_PTR_W-1:0];
            end
        end
    end

    // Granted vectors = 1 << mmenable, capped at 32; higher indices fold by masking.
    always_comb begin
        w_vec_mask = 5'h1F;
        case (cfg_interrupt_msi_mmenable[2:0])
            3'd0:    w_vec_mask = 5'h00;
            3'd1:    w_vec_mask = 5'h01;
            3'd2:    w_vec_mask = 5'h03;
            3'd3:    w_vec_mask = 5'h07;
            3'd4:    w_vec_mask = 5'h0F;
            default: w_vec_mask = 5'h1F;
        endcase
        w_vec_idx = 5'(w_pick) & w_vec_mask;
        w_ptr_nxt = (w_pick == c_PTR_LAST) ? '0 : w_pick + 1'b1;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_fail_evt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_interrupt_msi_enable[0] && w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A simultaneous sent+fail counts as a fail.
                if (cfg_interrupt_msi_fail || (w_timeout && !cfg_interrupt_msi_sent)) begin
                    w_fail_evt  = 1'b1;
                    w_state_nxt = S_BACKOFF;
                end else if (cfg_interrupt_msi_sent) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BACKOFF: begin
                if (r_backoff_cnt == c_BO_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-source clear (granted) and requeue (failed in-flight) masks.
    always_comb begin
        w_clear   = '0;
        w_requeue = '0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            w_clear[i]   = w_grant && (w_pick == c_PTR_W'(i));
            w_requeue[i] = w_fail_evt && (r_k == c_PTR_W'(i));
        end
    end

`ifdef PCIE_MSI_IRQ_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_WD_W-1:0] r_wd_cnt;

    // Watchdog counts consecutive WAIT cycles and restarts whenever WAIT is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending bits: a new request or requeue always wins over a grant clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | irq_req | w_requeue;
        end
    end

    // Grant bookkeeping: in-flight index, rotating pointer and the one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k       <= '0;
            r_ptr     <= '0;
            r_msi_int <= '0;
        end else begin
            r_msi_int <= '0;
            if (w_grant) begin
                r_k       <= w_pick;
                r_ptr     <= w_ptr_nxt;
                r_msi_int <= 32'd1 << w_vec_idx;
            end
        end
    end

    // Saturating fail counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_count <= '0;
        end else if (w_fail_evt && (r_fail_count != {FAIL_CNT_WIDTH{1'b1}})) begin
            r_fail_count <= r_fail_count + 1'b1;
        end
    end

    // Backoff counter runs only in BACKOFF and is zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_backoff_cnt <= '0;
        end else if ((r_state == S_BACKOFF) && (r_backoff_cnt != c_BO_LAST)) begin
            r_backoff_cnt <= r_backoff_cnt + 1'b1;
        end else begin
            r_backoff_cnt <= '0;
        end
    end

    assign irq_pending                       = r_pending;
    assign busy                              = (r_state != S_IDLE);
    assign fail_count                        = r_fail_count;
    assign cfg_interrupt_msi_int             = r_msi_int;
    assign cfg_interrupt_msi_function_number = 4'd0;
    assign cfg_interrupt_msi_attr            = 3'd0;

endmodule
`default_nettype wire
